// File: rtl/cache_tag_dir_if.sv
// Controller <-> tag directory bundle: lookup request/response, fill and flush.
interface cache_tag_dir_if #(
    parameter int TAG_WIDTH = 8,
    parameter int WAYS      = 4,
    parameter int SETS      = 4
);
    localparam int WIDX = $clog2(WAYS);
    localparam int SIDX = $clog2(SETS);

    logic                 req_valid;
    logic                 req_ready;
    logic [SIDX-1:0]      req_index;
    logic [TAG_WIDTH-1:0] req_tag;

    logic                 resp_valid;
    logic                 resp_hit;
    logic [WIDX-1:0]      resp_way;

    logic                 fill_valid;
    logic [SIDX-1:0]      fill_index;
    logic [WIDX-1:0]      fill_way;
    logic [TAG_WIDTH-1:0] fill_tag;

    logic                 flush;
    logic                 busy;

    // cache controller side
    modport master (
        output req_valid, req_index, req_tag,
        output fill_valid, fill_index, fill_way, fill_tag, flush,
        input  req_ready, resp_valid, resp_hit, resp_way, busy
    );

    // tag directory side
    modport slave (
        input  req_valid, req_index, req_tag,
        input  fill_valid, fill_index, fill_way, fill_tag, flush,
        output req_ready, resp_valid, resp_hit, resp_way, busy
    );
endinterface

// File: rtl/cache_tag_dir.sv
// Set-associative tag directory: per-way tag/valid storage with parallel
// compare, true-LRU ages per set, victim selection and invalidate-all flush.

// One way of the directory: tag + valid for every set, compare on read port.
module cache_tag_way #(
    parameter int TAG_WIDTH = 8,
    parameter int SETS      = 4,
    parameter int SIDX      = $clog2(SETS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [SIDX-1:0]      rd_index,
    input  logic [TAG_WIDTH-1:0] rd_tag,
    input  logic                 wr_en,
    input  logic [SIDX-1:0]      wr_index,
    input  logic [TAG_WIDTH-1:0] wr_tag,
    input  logic                 clr_en,
    input  logic [SIDX-1:0]      clr_index,
    output logic                 match,
    output logic                 vld
);
    logic [SETS-1:0][TAG_WIDTH-1:0] tags;
    logic [SETS-1:0]                valid;

    // Fill writes tag+valid; flush clears valid only (tags go stale).
    // Fill and clear never coincide: fills are blocked while flushing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tags  <= '0;
            valid <= '0;
        end else begin
            if (wr_en) begin
                tags[wr_index]  <= wr_tag;
                valid[wr_index] <= 1'b1;
            end
            if (clr_en)
                valid[clr_index] <= 1'b0;
        end
    end

    assign vld   = valid[rd_index];
    assign match = vld && (tags[rd_index] == rd_tag);
endmodule

module cache_tag_dir #(
    parameter int TAG_WIDTH = 8,
    parameter int WAYS      = 4,
    parameter int SETS      = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    cache_tag_dir_if.slave bus
);
    localparam int WIDX = $clog2(WAYS);
    localparam int SIDX = $clog2(SETS);

    typedef enum logic {IDLE, FLUSH} state_t;
    typedef logic [WAYS-1:0][WIDX-1:0] age_row_t;

    state_t                      state, state_nxt;
    logic [SIDX-1:0]             cnt, cnt_nxt;
    logic [SETS-1:0][WAYS-1:0][WIDX-1:0] age, age_nxt;

    logic            idle, accept, fill_en, clr_en;
    logic [WAYS-1:0] match, vld;
    logic            hit;
    logic [WIDX-1:0] hit_way, victim;
    logic            found;

    // Ages within a set are a permutation; touch makes w MRU (0) and
    // shifts every younger way one step older.
    function automatic age_row_t touch(input age_row_t row, input logic [WIDX-1:0] w);
        age_row_t r;
        r = row;
        for (int i = 0; i < WAYS; i++)
            if (row[i] < row[w])
                r[i] = row[i] + WIDX'(1);
        r[w] = '0;
        return r;
    endfunction

    assign idle    = (state == IDLE);
    assign accept  = bus.req_valid && idle;
    assign fill_en = bus.fill_valid && idle && !bus.flush;
    assign clr_en  = (state == FLUSH);

    genvar gw;
    generate
        for (gw = 0; gw < WAYS; gw++) begin : g_way
            cache_tag_way #(
                .TAG_WIDTH (TAG_WIDTH),
                .SETS      (SETS),
                .SIDX      (SIDX)
            ) u_way (
                .clk       (clk),
                .rst_n     (rst_n),
                .rd_index  (bus.req_index),
                .rd_tag    (bus.req_tag),
                .wr_en     (fill_en && (bus.fill_way == WIDX'(gw))),
                .wr_index  (bus.fill_index),
                .wr_tag    (bus.fill_tag),
                .clr_en    (clr_en),
                .clr_index (cnt),
                .match     (match[gw]),
                .vld       (vld[gw])
            );
        end
    endgenerate

    // Hit detection; a duplicate match (fill misuse) reports the lowest way.
    always_comb begin
        hit     = |match;
        hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--)
            if (match[w])
                hit_way = WIDX'(w);
    end

    // Victim: lowest invalid way, otherwise the LRU way of the indexed set.
    always_comb begin
        victim = '0;
        found  = 1'b0;
        for (int w = 0; w < WAYS; w++)
            if (!found && !vld[w]) begin
                victim = WIDX'(w);
                found  = 1'b1;
            end
        if (!found)
            for (int w = 0; w < WAYS; w++)
                if (age[bus.req_index][w] == WIDX'(WAYS - 1))
                    victim = WIDX'(w);
    end

    // Next ages: lookup-hit touch first, then fill touch, so a fill to the
    // same set ends MRU; a flushing set returns to the reset order.
    always_comb begin
        age_nxt = age;
        if (accept && hit)
            age_nxt[bus.req_index] = touch(age_nxt[bus.req_index], hit_way);
        if (fill_en)
            age_nxt[bus.fill_index] = touch(age_nxt[bus.fill_index], bus.fill_way);
        if (clr_en)
            for (int w = 0; w < WAYS; w++)
                age_nxt[cnt][w] = WIDX'(w);
    end

    // Age state register; reset order is way 0 MRU .. way WAYS-1 LRU.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    age[s][w] <= WIDX'(w);
        end else begin
            age <= age_nxt;
        end
    end

    // FSM state and flush set counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state: flush walks every set once, one set per cycle.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        bus.req_ready = 1'b0;
        bus.busy      = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.flush) begin
                    state_nxt = FLUSH;
                    cnt_nxt   = '0;
                end
            end
            FLUSH: begin
                bus.busy = 1'b1;
                cnt_nxt  = cnt + SIDX'(1);
                if (cnt == SIDX'(SETS - 1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered lookup result, one-cycle pulse per accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.resp_valid <= 1'b0;
            bus.resp_hit   <= 1'b0;
            bus.resp_way   <= '0;
        end else begin
            bus.resp_valid <= accept;
            if (accept) begin
                bus.resp_hit <= hit;
                bus.resp_way <= hit ? hit_way : victim;
            end
        end
    end
endmodule

// File: tb/tb_cache_tag_dir.sv
// Directed bench for cache_tag_dir with a recency-list reference model.
module tb_cache_tag_dir;
    localparam int TW = 8, WAYS = 4, SETS = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cache_tag_dir_if #(.TAG_WIDTH(TW), .WAYS(WAYS), .SETS(SETS)) bus();
    cache_tag_dir #(.TAG_WIDTH(TW), .WAYS(WAYS), .SETS(SETS)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int nvec = 0;
    int nmis = 0;

    // Reference model: tags/valids plus an MRU-first list of ways per set.
    bit [TW-1:0] m_tag[SETS][WAYS];
    bit          m_val[SETS][WAYS];
    int          m_list[SETS][$];
    bit          m_busy;
    int          m_left;
    bit          exp_rv, exp_hit;
    int          exp_way;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            m_list[s].delete();
            for (int w = 0; w < WAYS; w++) begin
                m_tag[s][w] = '0;
                m_val[s][w] = 1'b0;
                m_list[s].push_back(w);
            end
        end
        m_busy = 1'b0;
        m_left = 0;
        exp_rv = 1'b0;
    endtask

    task automatic m_touch(input int s, input int w);
        for (int i = 0; i < m_list[s].size(); i++)
            if (m_list[s][i] == w) begin
                m_list[s].delete(i);
                break;
            end
        m_list[s].push_front(w);
    endtask

    task automatic model_step();
        bit acc, fen;
        int s, hw;
        acc = bus.req_valid && !m_busy;
        fen = bus.fill_valid && !m_busy && !bus.flush;
        s   = int'(bus.req_index);
        hw  = -1;
        exp_rv = acc;
        if (acc) begin
            for (int w = 0; w < WAYS; w++)
                if (hw < 0 && m_val[s][w] && m_tag[s][w] == bus.req_tag) hw = w;
            if (hw >= 0) begin
                exp_hit = 1'b1;
                exp_way = hw;
                m_touch(s, hw);
            end else begin
                exp_hit = 1'b0;
                exp_way = m_list[s][WAYS-1];
                for (int w = WAYS - 1; w >= 0; w--)
                    if (!m_val[s][w]) exp_way = w;
            end
        end
        if (fen) begin
            m_tag[bus.fill_index][bus.fill_way] = bus.fill_tag;
            m_val[bus.fill_index][bus.fill_way] = 1'b1;
            m_touch(int'(bus.fill_index), int'(bus.fill_way));
        end
        if (m_busy) begin
            m_left--;
            if (m_left == 0) m_busy = 1'b0;
        end else if (bus.flush) begin
            // Nothing is observable mid-flush, so clear everything up front.
            m_busy = 1'b1;
            m_left = SETS;
            for (int t = 0; t < SETS; t++) begin
                m_list[t].delete();
                for (int w = 0; w < WAYS; w++) begin
                    m_val[t][w] = 1'b0;
                    m_list[t].push_back(w);
                end
            end
        end
    endtask

    // Model advances on the same edges as the DUT.
    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Every-cycle compare against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        chk("req_ready", int'(bus.req_ready), int'(!m_busy));
        chk("busy", int'(bus.busy), int'(m_busy));
        chk("resp_valid", int'(bus.resp_valid), int'(exp_rv));
        if (exp_rv) begin
            chk("resp_hit", int'(bus.resp_hit), int'(exp_hit));
            chk("resp_way", int'(bus.resp_way), exp_way);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.req_valid  = 1'b0; bus.req_index  = '0; bus.req_tag  = '0;
        bus.fill_valid = 1'b0; bus.fill_index = '0; bus.fill_way = '0;
        bus.fill_tag   = '0;   bus.flush      = 1'b0;
    endtask

    task automatic fill(input logic [1:0] s, input logic [1:0] w, input logic [7:0] t);
        bus.fill_valid = 1'b1; bus.fill_index = s; bus.fill_way = w; bus.fill_tag = t;
        step();
        bus.fill_valid = 1'b0;
    endtask

    task automatic lookup(input string name, input logic [1:0] s, input logic [7:0] t,
                          input int h, input int w);
        bus.req_valid = 1'b1; bus.req_index = s; bus.req_tag = t;
        step();
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk({name, "_v"}, int'(bus.resp_valid), 1);
        chk({name, "_hit"}, int'(bus.resp_hit), h);
        chk({name, "_way"}, int'(bus.resp_way), w);
    endtask

    int bcnt;

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle_in();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_resp_valid", int'(bus.resp_valid), 0);
        chk("rst_resp_hit", int'(bus.resp_hit), 0);
        chk("rst_resp_way", int'(bus.resp_way), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_ready", int'(bus.req_ready), 1);

        // No false hit on the zero reset tag.
        lookup("rst_tag0", 2'd2, 8'h00, 0, 0);

        // Fill set 1, hit, then LRU victim.
        for (int w = 0; w < 4; w++) fill(2'd1, 2'(w), 8'hA0 + 8'(w));
        lookup("hit_a2", 2'd1, 8'hA2, 1, 2);
        lookup("miss_b0", 2'd1, 8'hB0, 0, 0);
        lookup("hit_a0", 2'd1, 8'hA0, 1, 0);
        lookup("miss_b0_2", 2'd1, 8'hB0, 0, 1);
        fill(2'd1, 2'd1, 8'hB0);
        lookup("hit_b0", 2'd1, 8'hB0, 1, 1);

        // Back-to-back lookups, model-checked each cycle.
        bus.req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.req_index = 2'd1;
            bus.req_tag = (i[0]) ? 8'hA3 : 8'hA2;
            step();
        end
        idle_in();

        // Flush started with a request held; fill mid-flush is dropped.
        bus.flush = 1'b1; bus.req_valid = 1'b1; bus.req_index = 2'd1; bus.req_tag = 8'hA1;
        step();
        bus.flush = 1'b0;
        bcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
            bcnt++;
            if (bcnt == 2) begin
                bus.fill_valid = 1'b1; bus.fill_index = 2'd2; bus.fill_way = 2'd0;
                bus.fill_tag = 8'h55; bus.flush = 1'b1;
            end
            if (bcnt == 3) begin
                bus.fill_valid = 1'b0; bus.flush = 1'b0;
            end
        end
        chk("flush_cycles", bcnt, 4);
        step();
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("post_flush_hit", int'(bus.resp_hit), 0);
        chk("post_flush_way", int'(bus.resp_way), 0);
        lookup("midflush_fill", 2'd2, 8'h55, 0, 0);

        // Same-cycle lookup hit and fill into the same set.
        for (int w = 0; w < 4; w++) fill(2'd1, 2'(w), 8'hA0 + 8'(w));
        bus.req_valid = 1'b1; bus.req_index = 2'd1; bus.req_tag = 8'hA3;
        bus.fill_valid = 1'b1; bus.fill_index = 2'd1; bus.fill_way = 2'd0; bus.fill_tag = 8'hC0;
        step();
        idle_in();
        @(negedge clk);
        chk("combo_hit", int'(bus.resp_hit), 1);
        chk("combo_way", int'(bus.resp_way), 3);
        lookup("hit_c0", 2'd1, 8'hC0, 1, 0);
        chk("model_age_mru", m_list[1][0], 0);
        chk("model_age_2nd", m_list[1][1], 3);
        lookup("lru_after_combo", 2'd1, 8'hB0, 0, 1);

        // Reset during the second flush cycle.
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        step();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstflush_busy", int'(bus.busy), 0);
        chk("rstflush_ready", int'(bus.req_ready), 1);
        chk("rstflush_rv", int'(bus.resp_valid), 0);
        #1 rst_n = 1'b1;
        lookup("rst_a3", 2'd1, 8'hA3, 0, 0);
        lookup("rst_c0", 2'd1, 8'hC0, 0, 0);
        for (int w = 0; w < 4; w++) fill(2'd3, 2'(w), 8'h10 + 8'(w));
        lookup("rst_lru", 2'd3, 8'hEE, 0, 0);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
